// File: rtl/and8_operand_collector.sv
// and8_operand_collector: packs serial operand words into slots a..h for an 8-input AND stage
module and8_operand_collector #(
  parameter int Port_Num = 2,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       count
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t           r_state, w_next;
  logic [3:0]       r_count;
  logic [WIDTH-1:0] w_slot [8];
  logic             w_accept, w_done, w_release;
  if (Port_Num < 1 || Port_Num > 8) begin : g_bad_port_num
    $error("and8_operand_collector: Port_Num must be 1..8");
  end
  assign in_ready  = ~rst & (r_state == FILL);
  assign w_accept  = in_valid & in_ready;
  assign w_done    = w_accept & (in_last | (r_count == 4'(Port_Num - 1)));
  assign w_release = (r_state == HOLD) & out_ready;
  assign out_valid = r_state == HOLD;
  assign count     = r_count;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FILL;
    else     r_state <= w_next;
  // close the group on the final accept, reopen when the consumer takes it
  always_comb w_next = w_done ? HOLD : (w_release ? FILL : r_state);
  // count doubles as the write index of the next slot
  always_ff @(posedge clk or posedge rst)
    if (rst)            r_count <= '0;
    else if (w_release) r_count <= '0;
    else if (w_accept)  r_count <= r_count + 4'd1;
  for (genvar i = 0; i < 8; i++) begin : g_slot
    if (i < Port_Num) begin : g_reg
      logic [WIDTH-1:0] r_q;
      // slot loads its word when addressed, returns to all-ones on handoff
      always_ff @(posedge clk or posedge rst)
        if (rst)                                  r_q <= '1;
        else if (w_release)                       r_q <= '1;
        else if (w_accept && r_count == 4'(i))    r_q <= in_data;
      assign w_slot[i] = r_q;
    end else begin : g_ones
      assign w_slot[i] = '1;
    end
  end
  assign a = w_slot[0];
  assign b = w_slot[1];
  assign c = w_slot[2];
  assign d = w_slot[3];
  assign e = w_slot[4];
  assign f = w_slot[5];
  assign g = w_slot[6];
  assign h = w_slot[7];
endmodule

// File: tb/tb_and8_operand_collector.sv
// tb_and8_operand_collector: directed checks over five parameterisations of the collector
module tb_and8_operand_collector;
  logic       clk = 1'b0;
  logic       rs   [5];
  logic       iv   [5];
  logic       ir   [5];
  logic       il   [5];
  logic       ov   [5];
  logic       ordy [5];
  logic [7:0] id   [5];
  logic [3:0] cn   [5];
  logic [7:0] sl   [5][8];
  logic [6:0] s7   [8];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  and8_operand_collector #(.Port_Num(2), .WIDTH(7)) u0 (
    .clk(clk), .rst(rs[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][6:0]), .in_last(il[0]),
    .a(s7[0]), .b(s7[1]), .c(s7[2]), .d(s7[3]), .e(s7[4]), .f(s7[5]), .g(s7[6]), .h(s7[7]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .count(cn[0]));
  and8_operand_collector #(.Port_Num(8), .WIDTH(8)) u1 (
    .clk(clk), .rst(rs[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_last(il[1]),
    .a(sl[1][0]), .b(sl[1][1]), .c(sl[1][2]), .d(sl[1][3]), .e(sl[1][4]), .f(sl[1][5]), .g(sl[1][6]), .h(sl[1][7]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .count(cn[1]));
  and8_operand_collector #(.Port_Num(4), .WIDTH(8)) u2 (
    .clk(clk), .rst(rs[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .in_last(il[2]),
    .a(sl[2][0]), .b(sl[2][1]), .c(sl[2][2]), .d(sl[2][3]), .e(sl[2][4]), .f(sl[2][5]), .g(sl[2][6]), .h(sl[2][7]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .count(cn[2]));
  and8_operand_collector #(.Port_Num(3), .WIDTH(8)) u3 (
    .clk(clk), .rst(rs[3]), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]), .in_last(il[3]),
    .a(sl[3][0]), .b(sl[3][1]), .c(sl[3][2]), .d(sl[3][3]), .e(sl[3][4]), .f(sl[3][5]), .g(sl[3][6]), .h(sl[3][7]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .count(cn[3]));
  and8_operand_collector #(.Port_Num(1), .WIDTH(8)) u4 (
    .clk(clk), .rst(rs[4]), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(id[4]), .in_last(il[4]),
    .a(sl[4][0]), .b(sl[4][1]), .c(sl[4][2]), .d(sl[4][3]), .e(sl[4][4]), .f(sl[4][5]), .g(sl[4][6]), .h(sl[4][7]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .count(cn[4]));

  function automatic logic [63:0] pk(input int n);
    return {sl[n][0], sl[n][1], sl[n][2], sl[n][3], sl[n][4], sl[n][5], sl[n][6], sl[n][7]};
  endfunction

  function automatic logic [55:0] pk7();
    return {s7[0], s7[1], s7[2], s7[3], s7[4], s7[5], s7[6], s7[7]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 5; n++) begin
      rs[n] = 1'b1; iv[n] = 1'b0; il[n] = 1'b0; ordy[n] = 1'b0; id[n] = 8'h00;
    end
    #3;
    total++;
    if (pk7() !== {8{7'h7F}}) begin bad++; $display("FAIL reset_slots7 got=%h exp=%h", pk7(), {8{7'h7F}}); end
    for (int n = 0; n < 5; n++) begin
      total++;
      if ({ir[n], ov[n], cn[n]} !== 6'b0) begin bad++; $display("FAIL reset_ctrl[%0d] got=%b exp=000000", n, {ir[n], ov[n], cn[n]}); end
      if (n > 0) begin
        total++;
        if (pk(n) !== {64{1'b1}}) begin bad++; $display("FAIL reset_slots[%0d] got=%h exp=all-ones", n, pk(n)); end
      end
    end
    tick();
    for (int n = 0; n < 5; n++) rs[n] = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      total++;
      if ({ir[n], ov[n]} !== 2'b10) begin bad++; $display("FAIL post_reset_ready[%0d] got=%b exp=10", n, {ir[n], ov[n]}); end
    end
  endtask

  task automatic test_back_to_back();
    ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 8'h7F;
    tick();
    total++;
    if ({ov[0], cn[0]} !== 5'b0_0001) begin bad++; $display("FAIL p2_first got=%b exp=00001", {ov[0], cn[0]}); end
    id[0] = 8'h3C;
    tick();
    iv[0] = 1'b0;
    total++;
    if ({ov[0], ir[0], cn[0]} !== 6'b10_0010) begin bad++; $display("FAIL p2_hold_ctrl got=%b exp=100010", {ov[0], ir[0], cn[0]}); end
    total++;
    if (pk7() !== {7'h7F, 7'h3C, {6{7'h7F}}}) begin bad++; $display("FAIL p2_slots got=%h exp=%h", pk7(), {7'h7F, 7'h3C, {6{7'h7F}}}); end
    tick();
    total++;
    if ({ov[0], ir[0], cn[0]} !== 6'b01_0000) begin bad++; $display("FAIL p2_release got=%b exp=010000", {ov[0], ir[0], cn[0]}); end
    total++;
    if (pk7() !== {8{7'h7F}}) begin bad++; $display("FAIL p2_cleared got=%h exp=%h", pk7(), {8{7'h7F}}); end
    tick();
    total++;
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL p2_single_pulse got=%b exp=0", ov[0]); end
  endtask

  task automatic test_full_group();
    ordy[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      iv[1] = 1'b1; id[1] = 8'(k);
      tick();
      total++;
      if ({ov[1], cn[1]} !== {k == 8, 4'(k)}) begin bad++; $display("FAIL p8_load%0d got=%b exp=%b", k, {ov[1], cn[1]}, {k == 8, 4'(k)}); end
      iv[1] = 1'b0;
      tick();
    end
    iv[1] = 1'b1; id[1] = 8'h99;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if ({ov[1], ir[1], cn[1], pk(1)} !== {2'b10, 4'd8, 64'h0102030405060708}) begin
        bad++; $display("FAIL p8_hold%0d got=%b/%b/%0d/%h exp=1/0/8/0102030405060708", k, ov[1], ir[1], cn[1], pk(1));
      end
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    tick();
    ordy[1] = 1'b0;
    total++;
    if ({ov[1], ir[1], cn[1], pk(1)} !== {2'b01, 4'd0, {64{1'b1}}}) begin
      bad++; $display("FAIL p8_release got=%b/%b/%0d/%h exp=0/1/0/all-ones", ov[1], ir[1], cn[1], pk(1));
    end
  endtask

  task automatic test_early_last();
    ordy[2] = 1'b0; iv[2] = 1'b1; il[2] = 1'b1; id[2] = 8'hAA;
    tick();
    il[2] = 1'b0;
    total++;
    if ({ov[2], cn[2], pk(2)} !== {1'b1, 4'd1, 8'hAA, {56{1'b1}}}) begin
      bad++; $display("FAIL p4_last got=%b/%0d/%h exp=1/1/AAFFFFFFFFFFFFFF", ov[2], cn[2], pk(2));
    end
    id[2] = 8'h11;
    tick();
    id[2] = 8'h22;
    tick();
    total++;
    if ({ov[2], ir[2], cn[2], pk(2)} !== {2'b10, 4'd1, 8'hAA, {56{1'b1}}}) begin
      bad++; $display("FAIL p4_no_accept got=%b/%b/%0d/%h exp=1/0/1/AAFFFFFFFFFFFFFF", ov[2], ir[2], cn[2], pk(2));
    end
    iv[2] = 1'b0; ordy[2] = 1'b1;
    tick();
    ordy[2] = 1'b0;
    total++;
    if ({ov[2], cn[2], pk(2)} !== {1'b0, 4'd0, {64{1'b1}}}) begin
      bad++; $display("FAIL p4_release got=%b/%0d/%h exp=0/0/all-ones", ov[2], cn[2], pk(2));
    end
  endtask

  task automatic test_async_reset();
    ordy[3] = 1'b0; iv[3] = 1'b1; id[3] = 8'h05;
    tick();
    id[3] = 8'h06;
    tick();
    iv[3] = 1'b0;
    total++;
    if ({cn[3], pk(3)} !== {4'd2, 16'h0506, {48{1'b1}}}) begin bad++; $display("FAIL p3_partial got=%0d/%h", cn[3], pk(3)); end
    #2 rs[3] = 1'b1;
    #1;
    total++;
    if ({ov[3], ir[3], cn[3], pk(3)} !== {2'b00, 4'd0, {64{1'b1}}}) begin
      bad++; $display("FAIL p3_async got=%b/%b/%0d/%h exp=0/0/0/all-ones", ov[3], ir[3], cn[3], pk(3));
    end
    tick();
    rs[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[3] = 1'b1; id[3] = 8'(8'h0A + k);
      tick();
    end
    iv[3] = 1'b0;
    total++;
    if ({ov[3], cn[3], pk(3)} !== {1'b1, 4'd3, 24'h0A0B0C, {40{1'b1}}}) begin
      bad++; $display("FAIL p3_new_group got=%b/%0d/%h exp=1/3/0A0B0CFFFFFFFFFF", ov[3], cn[3], pk(3));
    end
  endtask

  task automatic test_single_slot();
    ordy[4] = 1'b1; iv[4] = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      id[4] = 8'(k);
      tick();
      total++;
      if ({ov[4], cn[4], pk(4)} !== {1'b1, 4'd1, 8'(k), {56{1'b1}}}) begin
        bad++; $display("FAIL p1_group%0d got=%b/%0d/%h exp=1/1/%h", k, ov[4], cn[4], pk(4), {8'(k), {56{1'b1}}});
      end
      tick();
      total++;
      if ({ov[4], ir[4], sl[4][0]} !== {2'b01, 8'hFF}) begin
        bad++; $display("FAIL p1_gap%0d got=%b/%b/%h exp=0/1/FF", k, ov[4], ir[4], sl[4][0]);
      end
    end
    iv[4] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_group();
    test_early_last();
    test_async_reset();
    test_single_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
